// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline-stage buffer and its integration
// as the execute-to-memory boundary.
package pipe_pkg;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [31:0] alu_result;
    logic [4:0]  rd;
    logic [31:0] rd2;
    logic [31:0] pc_cur;
    logic [2:0]  funct3;
  } ex_mem_payload_t;

  localparam int EX_MEM_W = $bits(ex_mem_payload_t);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  // Number of valid entries implied by a buffer state.
  function automatic logic [1:0] occ_of(input buf_state_t st);
    case (st)
      ONE:     occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register with a valid bit. Clear drops the valid bit but keeps
// the data, so a flushed slot still shows its last payload.
module pipe_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (i_clear)
        r_valid <= 1'b0;
      else if (i_load)
        r_valid <= 1'b1;
      if (i_load && !i_clear)
        r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline-stage buffer with optional skid entry,
// flush-driven bubble insertion and a saturating stall counter.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              clear_stats,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

  buf_state_t        r_state;
  logic              r_in_ready;
  logic [1:0]        r_occupancy;
  logic [CNT_W-1:0]  r_stall;

  buf_state_t        w_state_next;
  logic              w_accept;
  logic              w_emit;
  logic              w_main_load;
  logic              w_main_clear;
  logic              w_skid_load;
  logic              w_skid_clear;
  logic              w_main_valid;
  logic [DATA_W-1:0] w_main_data;
  logic [DATA_W-1:0] w_main_din;
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;

  assign w_accept = in_valid & in_ready;
  assign w_emit   = w_main_valid & out_ready;

  // Without a skid entry, ONE can only accept while emitting, so FULL is unreachable.
  always_comb begin
    w_state_next = r_state;
    w_main_load  = 1'b0;
    w_main_clear = 1'b0;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
    if (flush) begin
      w_state_next = EMPTY;
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_main_load  = 1'b1;
            w_state_next = ONE;
          end
        end
        ONE: begin
          if (w_accept && w_emit) begin
            w_main_load = 1'b1;
          end else if (w_accept) begin
            w_skid_load  = 1'b1;
            w_state_next = FULL;
          end else if (w_emit) begin
            w_main_clear = 1'b1;
            w_state_next = EMPTY;
          end
        end
        FULL: begin
          if (w_emit) begin
            w_main_load  = 1'b1;
            w_skid_clear = 1'b1;
            w_state_next = ONE;
          end
        end
        default: begin
          w_state_next = EMPTY;
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign w_main_din = w_skid_valid ? w_skid_data : in_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_occupancy <= 2'd0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next != FULL);
      r_occupancy <= occ_of(w_state_next);
    end
  end

  pipe_slot #(.DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (reset),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_din),
    .o_valid (w_main_valid),
    .o_data  (w_main_data)
  );

  generate
    if (SKID_EN) begin : g_skid
      pipe_slot #(.DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
      );
      assign in_ready = r_in_ready;
    end else begin : g_no_skid
      assign w_skid_valid = 1'b0;
      assign w_skid_data  = '0;
      assign in_ready     = !w_main_valid | out_ready;
    end
  endgenerate

  // clear_stats wins over a same-cycle increment; flush does not touch the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_stall <= '0;
    else if (clear_stats)
      r_stall <= '0;
    else if (w_main_valid && !out_ready && r_stall != STALL_MAX)
      r_stall <= r_stall + 1'b1;
  end

  assign out_valid    = w_main_valid;
  assign out_data     = w_main_data;
  assign occupancy    = r_occupancy;
  assign stall_cycles = r_stall;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: skid instance (CNT_W=4) and single-entry instance.
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush, a_clear;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;
  logic [3:0]  a_stall;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush, b_clear;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_occ;
  logic [15:0] b_stall;

  logic [31:0] a_exp_q[$];
  logic [31:0] b_exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  pipe_stage_buf #(.DATA_W(32), .SKID_EN(1'b1), .CNT_W(4)) u_a (
    .clk(clk), .reset(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .flush(a_flush), .clear_stats(a_clear),
    .occupancy(a_occ), .stall_cycles(a_stall)
  );

  pipe_stage_buf #(.DATA_W(32), .SKID_EN(1'b0), .CNT_W(16)) u_b (
    .clk(clk), .reset(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .flush(b_flush), .clear_stats(b_clear),
    .occupancy(b_occ), .stall_cycles(b_stall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("check %-18s got 0x%0h expected 0x%0h ok", name, act, exp);
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: every emit must match the oldest expected payload.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (a_exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL a_emit: got 0x%0h expected no emission", a_out_data);
      end else begin
        check("a_emit", a_out_data, a_exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      if (b_exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL b_emit: got 0x%0h expected no emission", b_out_data);
      end else begin
        check("b_emit", b_out_data, b_exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_out_ready = 0; a_flush = 0; a_clear = 0; a_in_data = '0;
    b_in_valid = 0; b_out_ready = 0; b_flush = 0; b_clear = 0; b_in_data = '0;
    #2;
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_occ", a_occ, 0);
    check("rst_stall", a_stall, 0);
    step();
    rst = 1'b0;

    // Streaming with out_ready held high.
    a_out_ready = 1;
    a_in_valid = 1;
    for (int i = 1; i <= 3; i++) begin
      a_in_data = 32'h11 * i;
      a_exp_q.push_back(32'h11 * i);
      step();
      check("stream_in_ready", a_in_ready, 1);
      check("stream_occ", a_occ, 1);
    end
    a_in_valid = 0;
    step();
    check("stream_drained", a_occ, 0);
    check("stream_stall", a_stall, 0);

    // Back-pressure fills the skid entry.
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'hA1; a_exp_q.push_back(32'hA1);
    step();
    check("bp_occ1", a_occ, 1);
    a_in_data = 32'hA2; a_exp_q.push_back(32'hA2);
    step();
    a_in_valid = 0;
    check("bp_occ2", a_occ, 2);
    check("bp_in_ready", a_in_ready, 0);
    check("bp_stall1", a_stall, 1);
    step();
    step();
    check("bp_stall3", a_stall, 3);
    a_out_ready = 1;
    step();
    check("bp_release_occ", a_occ, 1);
    check("bp_release_rdy", a_in_ready, 1);
    check("bp_hold_stall", a_stall, 3);
    step();
    check("bp_empty", a_occ, 0);

    // Flush while FULL with a same-cycle incoming 0xFF.
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'hB1;
    step();
    a_in_data = 32'hB2;
    step();
    check("fl_full", a_occ, 2);
    a_in_data = 32'hFF; a_flush = 1;
    step();
    a_flush = 0; a_in_valid = 0;
    check("fl_occ", a_occ, 0);
    check("fl_out_valid", a_out_valid, 0);
    check("fl_stall_kept", a_stall, 5);
    a_out_ready = 1;
    step();
    a_in_valid = 1; a_in_data = 32'h05; a_exp_q.push_back(32'h05);
    step();
    a_in_valid = 0;
    step();
    check("fl_after_occ", a_occ, 0);

    // Saturation of the 4-bit stall counter and clear priority.
    a_clear = 1;
    step();
    a_clear = 0;
    check("sat_cleared", a_stall, 0);
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'hC1;
    step();
    a_in_valid = 0;
    repeat (20) step();
    check("sat_15", a_stall, 15);
    a_clear = 1;
    step();
    a_clear = 0;
    check("sat_clear_beats", a_stall, 0);
    step();
    check("sat_resume", a_stall, 1);
    a_exp_q.push_back(32'hC1);
    a_out_ready = 1;
    step();
    check("sat_drain", a_occ, 0);

    // Asynchronous reset while FULL.
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'hD1;
    step();
    a_in_data = 32'hD2;
    step();
    a_in_valid = 0;
    check("ar_full", a_occ, 2);
    #2 rst = 1'b1;
    #1;
    check("ar_out_valid", a_out_valid, 0);
    check("ar_occ", a_occ, 0);
    check("ar_in_ready", a_in_ready, 1);
    check("ar_stall", a_stall, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    step();
    a_out_ready = 1;
    a_in_valid = 1; a_in_data = 32'h01; a_exp_q.push_back(32'h01);
    step();
    a_in_valid = 0;
    check("ar_push_valid", a_out_valid, 1);
    check("ar_push_occ", a_occ, 1);
    step();
    check("ar_push_drain", a_occ, 0);

    // Single-entry instance: combinational in_ready.
    b_out_ready = 0;
    b_in_valid = 1; b_in_data = 32'h3C; b_exp_q.push_back(32'h3C);
    step();
    check("b_occ1", b_occ, 1);
    b_in_data = 32'h55;
    #1;
    check("b_ready_low", b_in_ready, 0);
    step();
    check("b_hold_occ", b_occ, 1);
    check("b_stall", b_stall, 1);
    b_out_ready = 1; b_in_data = 32'h7E; b_exp_q.push_back(32'h7E);
    #1;
    check("b_ready_comb", b_in_ready, 1);
    step();
    check("b_replace_occ", b_occ, 1);
    b_in_valid = 0;
    step();
    check("b_drain", b_occ, 0);

    // Flush with a same-cycle emit: the emit completes, the input is dropped.
    b_out_ready = 0;
    b_in_valid = 1; b_in_data = 32'h99; b_exp_q.push_back(32'h99);
    step();
    b_out_ready = 1; b_in_data = 32'hAA; b_flush = 1;
    step();
    b_flush = 0; b_in_valid = 0;
    check("b_flush_occ", b_occ, 0);
    check("b_flush_valid", b_out_valid, 0);
    step();

    check("a_queue_empty", a_exp_q.size(), 0);
    check("b_queue_empty", b_exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised, elastic pipeline-stage buffer for inter-stage payloads (first use: execute→memory bundle).
- Replaces the plain per-cycle register boundary with a valid/ready handshake, an optional skid entry, flush (bubble insertion) and a saturating stall counter.
- Lets the memory stage back-pressure execute without a combinational ready chain through the whole pipe.

Parameters:
- DATA_W, 32, payload width in bits; the integration instance sets it to the width of ex_mem_payload_t.
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16, stall-counter width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  buffer can accept this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  downstream payload valid.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DATA_W  downstream payload.
- flush  input  1  discard all held and incoming payloads (branch or exception kill).
- clear_stats  input  1  synchronous clear of stall_cycles.
- occupancy  output  2  entries held: 0, 1 or 2.
- stall_cycles  output  CNT_W  saturating count of back-pressured cycles.

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, out_data='0, in_ready=1, occupancy=0, stall_cycles=0. A reset asserted mid-transfer drops all entries immediately; no partial state survives.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Emit = out_valid & out_ready.
  - in_data is sampled only on accept.
  - While out_valid & !out_ready, out_data and out_valid stay stable until emit or flush.
- Latency: 1 cycle. A payload accepted at edge N is on out_data after edge N. There is no combinational in→out path.
- SKID_EN=1: states EMPTY(occ 0), ONE(main valid), FULL(main + skid valid). in_ready = (state != FULL); it is a registered output.
  - EMPTY: accept → ONE (main ← in_data).
  - ONE, accept & emit: stay ONE (main ← in_data).
  - ONE, accept & !emit: → FULL (skid ← in_data).
  - ONE, emit only: → EMPTY.
  - FULL, emit: → ONE (main ← skid). No accept is possible in FULL.
  - FULL, no emit: hold.
  - Ordering is strictly FIFO. Skid data is never emitted before main data.
- SKID_EN=0: single entry. in_ready = !out_valid | out_ready (combinational from out_ready). occupancy never exceeds 1. Accept & emit in the same cycle replaces the entry.
- flush:
  - Dominates everything. At the flush edge all entries are invalidated, state → EMPTY, occupancy=0.
  - Any same-cycle input is discarded even if in_ready=1. The upstream still sees the handshake, by design: flush kills the younger op.
  - A same-cycle emit still completes downstream, since out_valid was 1 during that cycle.
  - out_data is not cleared by flush, only by reset. Its value is don't-care while out_valid=0.
- stall_cycles:
  - +1 on every edge where out_valid & !out_ready.
  - Saturates at 2^CNT_W−1; no wrap.
  - clear_stats → 0 at the edge and beats a same-cycle increment.
  - Unaffected by flush.
- occupancy always equals the number of valid entries after the edge. out_valid = (occupancy != 0).

Decomposition:
- Shared package pipe_pkg holds:
  - typedef ex_mem_payload_t, a packed struct of the control fields plus alu_result, rd, rd2, pc_cur, funct3;
  - localparam EX_MEM_W = $bits(ex_mem_payload_t);
  - typedef buf_state_t enum {EMPTY, ONE, FULL}.
- One natural sub-module, pipe_slot: a DATA_W register with valid bit, load enable, clear and async reset. Instantiate it twice for main and skid; the skid slot is generate-gated on SKID_EN.
- The stall counter stays inline.

Test Plan:
- Streaming, SKID_EN=1: out_ready held 1, push 0x11,0x22,0x33 on consecutive cycles → out_data 0x11,0x22,0x33 one cycle later each, in_ready stays 1, occupancy stays 1, stall_cycles=0.
- Back-pressure: out_ready=0, push 0xA1 then 0xA2 → occupancy 2, in_ready=0, stall_cycles counts 1,2,3…. Release out_ready → emits 0xA1 then 0xA2, in_ready=1 the cycle after 0xA1 leaves.
- Flush while FULL with in_valid=1 (0xFF) → next cycle occupancy=0, out_valid=0; 0xFF is never emitted. Subsequent push 0x05 is emitted normally.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles → stall_cycles=15. Assert clear_stats with the stall still active → 0 on that edge, then resumes counting at 1.
- SKID_EN=0: out_ready=0 with one entry held → in_ready=0 in the same cycle. Raise out_ready with in_valid=1 (0x7E) → in_ready=1 combinationally, 0x7E replaces the entry, occupancy stays 1.
- Async reset asserted mid-cycle while FULL → out_valid=0, occupancy=0, in_ready=1, stall_cycles=0 without waiting for a clk edge. Post-reset push 0x01 → emitted after 1 cycle.
